// File: rtl/serial_rx_fifo_if.sv
// Bundle of the write-strobe, pop handshake and status signals of serial_rx_fifo.
// The master side is the environment (UART receiver plus consumer); the FIFO
// itself connects through the slave modport.
interface serial_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  i_wr;
  logic [7:0]            i_data;
  logic                  i_rd;
  logic                  i_clr_ovf;
  logic                  o_valid;
  logic [7:0]            o_data;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_full;
  logic                  o_afull;
  logic                  o_overflow;

  modport master (
    output i_wr, i_data, i_rd, i_clr_ovf,
    input  o_valid, o_data, o_count, o_full, o_afull, o_overflow
  );

  modport slave (
    input  i_wr, i_data, i_rd, i_clr_ovf,
    output o_valid, o_data, o_count, o_full, o_afull, o_overflow
  );
endinterface

// File: rtl/serial_rx_fifo.sv
// Receive-side byte FIFO sitting directly behind serial_rx.
// The UART receiver cannot be stalled, so a write into a full FIFO is dropped
// (unless a pop frees the slot in the same cycle) and a sticky overflow flag
// records the loss. The head byte is presented first-word-fall-through.
module serial_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AFULL_LVL  = 12
) (
  input logic             i_clk,
  input logic             i_rst,
  serial_rx_fifo_if.slave bus
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);

  logic [7:0]            mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  do_wr;
  logic                  do_rd;
  logic                  drop;
  logic                  overflow;

  // Occupancy is the modular pointer difference; the extra MSB separates full from empty.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A full FIFO can still take a write when the same cycle pops the head.
  assign do_rd = bus.i_rd && !empty;
  assign do_wr = bus.i_wr && (!full || bus.i_rd);
  assign drop  = bus.i_wr && full && !bus.i_rd;

  // Pointer update; reset discards all stored bytes and any concurrent strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; not cleared on reset, only written on an accepted byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst && do_wr) mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.i_data;
  end

  // Sticky loss flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge i_clk) begin
    if (i_rst)              overflow <= 1'b0;
    else if (drop)          overflow <= 1'b1;
    else if (bus.i_clr_ovf) overflow <= 1'b0;
  end

  assign bus.o_valid    = !empty;
  assign bus.o_data     = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign bus.o_count    = count;
  assign bus.o_full     = full;
  assign bus.o_afull    = (count >= AFULL_C);
  assign bus.o_overflow = overflow;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Self-checking bench for serial_rx_fifo: a table of single-cycle vectors with
// hand-computed results, then hand-written fill/wrap, overflow, simultaneous
// and mid-stream reset sequences checked against a small queue model.
module tb_serial_rx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int AFULL_LVL  = 12;

  logic i_clk;
  logic i_rst;

  serial_rx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  serial_rx_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    int         e_count;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [12];
  logic [7:0] model_q [$];

  // Free-running 100 MHz clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in and settle just after the edge.
  task automatic applyStimulus(input logic rst, input logic wr, input logic [7:0] data,
                               input logic rd, input logic clr);
    i_rst         = rst;
    bus.i_wr      = wr;
    bus.i_data    = data;
    bus.i_rd      = rd;
    bus.i_clr_ovf = clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic e_valid, input logic [7:0] e_data,
                             input int e_count, input logic e_ovf);
    compare({name, ".valid"}, 32'(bus.o_valid), 32'(e_valid));
    if (e_valid) compare({name, ".data"}, 32'(bus.o_data), 32'(e_data));
    compare({name, ".count"}, 32'(bus.o_count), 32'(e_count));
    compare({name, ".full"}, 32'(bus.o_full), 32'(e_count == 16));
    compare({name, ".afull"}, 32'(bus.o_afull), 32'(e_count >= AFULL_LVL));
    compare({name, ".ovf"}, 32'(bus.o_overflow), 32'(e_ovf));
  endtask

  // Model-tracked step: update the queue like the FIFO should, then check.
  task automatic modelStep(input string name, input logic wr, input logic [7:0] data,
                           input logic rd, input logic clr, input logic e_ovf);
    int n;
    n = model_q.size();
    applyStimulus(1'b0, wr, data, rd, clr);
    if (rd && n > 0) void'(model_q.pop_front());
    if (wr && (n < 16 || rd)) model_q.push_back(data);
    checkOutput(name, model_q.size() > 0, (model_q.size() > 0) ? model_q[0] : 8'h00,
                model_q.size(), e_ovf);
  endtask

  initial begin
    i_rst = 1'b1; bus.i_wr = 1'b0; bus.i_data = 8'h00; bus.i_rd = 1'b0; bus.i_clr_ovf = 1'b0;

    //            rst  wr   data   rd   clr  valid data  cnt ovf
    vecs[0]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h4B, 1'b0, 1'b0, 1'b1, 8'h4B, 1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 2, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                  vecs[i].e_count, vecs[i].e_ovf);
    end

    // Fill to full and drain, three rounds so both pointers wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++)
        modelStep($sformatf("fill%0d_%0d", r, i), 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
        compare($sformatf("drain%0d_%0d.head", r, i), 32'(bus.o_data), 32'(i));
        modelStep($sformatf("drain%0d_%0d", r, i), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
    end

    // Overflow: drop, clear, and clear colliding with another drop.
    for (int i = 0; i < 16; i++)
      modelStep($sformatf("ofill%0d", i), 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    modelStep("drop_aa", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    compare("drop_aa.head00", 32'(bus.o_data), 32'h00);
    modelStep("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    modelStep("drop_with_clr", 1'b1, 8'hBB, 1'b0, 1'b1, 1'b1);

    // Full with simultaneous write and pop: count holds, 8'h55 comes out last.
    modelStep("full_wr_rd", 1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    modelStep("clr_ovf2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      compare($sformatf("sdrain%0d.head", i), 32'(bus.o_data), (i < 15) ? 32'(i + 1) : 32'h55);
      modelStep($sformatf("sdrain%0d", i), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    modelStep("rd_empty", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a stream with a concurrent write and pop.
    for (int i = 0; i < 7; i++)
      modelStep($sformatf("mfill%0d", i), 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    model_q.delete();
    checkOutput("mid_reset", 1'b0, 8'h00, 0, 1'b0);
    modelStep("post_rst_wr31", 1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    modelStep("post_rst_wr32", 1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
    compare("post_rst.head31", 32'(bus.o_data), 32'h31);
    modelStep("post_rst_pop1", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    modelStep("post_rst_pop2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
